// File: rtl/conv_pkg.sv
// Shared types and size helpers for the convolution controller, its datapath and the output FIFO.
package conv_pkg;

  typedef enum logic [2:0] {IDLE, CLEAR, ACCUM, FLUSH, EMIT, DONE} conv_state_t;

  // Counter/address width; a value range of one still needs a 1-bit signal.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned calc_m(input int unsigned n, input int unsigned k);
    return n - k + 1;
  endfunction

  function automatic int unsigned calc_xaw(input int unsigned n);
    return cnt_w(n * n);
  endfunction

  function automatic int unsigned calc_waw(input int unsigned k);
    return cnt_w(k * k);
  endfunction

  localparam int unsigned N_DEF   = 8;
  localparam int unsigned K_DEF   = 3;
  localparam int unsigned M_DEF   = calc_m(N_DEF, K_DEF);
  localparam int unsigned XAW_DEF = calc_xaw(N_DEF);
  localparam int unsigned WAW_DEF = calc_waw(K_DEF);

endpackage

// File: rtl/conv_ctrl_if.sv
// Control/handshake bundle between conv_ctrl and the MAC, memories and output FIFO.
interface conv_ctrl_if #(
  parameter int unsigned XAW = 6,
  parameter int unsigned WAW = 4
);
  logic           start;
  logic           busy;
  logic           done;
  logic [XAW-1:0] x_addr;
  logic [WAW-1:0] w_addr;
  logic           mac_clr;
  logic           mac_en;
  logic           OUT_AXIS_TVALID;
  logic           OUT_AXIS_TREADY;

  modport master (
    input  start, OUT_AXIS_TREADY,
    output busy, done, x_addr, w_addr, mac_clr, mac_en, OUT_AXIS_TVALID
  );

  modport slave (
    output start, OUT_AXIS_TREADY,
    input  busy, done, x_addr, w_addr, mac_clr, mac_en, OUT_AXIS_TVALID
  );
endinterface

// File: rtl/conv_idx_counter.sv
// Generic 2-D wrapping counter: inner runs 0..INNER-1, carrying into outer 0..OUTER-1.
module conv_idx_counter
  import conv_pkg::*;
#(
  parameter int unsigned INNER = 3,
  parameter int unsigned OUTER = 3,
  parameter int unsigned IW    = cnt_w(INNER),
  parameter int unsigned OW    = cnt_w(OUTER)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr_i,
  input  logic          inc_i,
  output logic [IW-1:0] inner_o,
  output logic [OW-1:0] outer_o,
  output logic          last_o
);
  logic [IW-1:0] in_q, in_d;
  logic [OW-1:0] out_q, out_d;

  always_comb begin
    in_d  = in_q;
    out_d = out_q;
    if (clr_i) begin
      in_d  = '0;
      out_d = '0;
    end else if (inc_i) begin
      if (in_q == IW'(INNER - 1)) begin
        in_d  = '0;
        out_d = (out_q == OW'(OUTER - 1)) ? '0 : out_q + 1'b1;
      end else begin
        in_d = in_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_q  <= '0;
      out_q <= '0;
    end else begin
      in_q  <= in_d;
      out_q <= out_d;
    end
  end

  assign inner_o = in_q;
  assign outer_o = out_q;
  assign last_o  = (in_q == IW'(INNER - 1)) && (out_q == OW'(OUTER - 1));
endmodule

// File: rtl/conv_ctrl.sv
// Walks a KxK kernel over an NxN input, sequencing memory reads, MAC strobes and the output push.
module conv_ctrl
  import conv_pkg::*;
#(
  parameter int unsigned N = N_DEF,
  parameter int unsigned K = K_DEF
) (
  input  logic         clk,
  input  logic         reset,
  conv_ctrl_if.master  bus
);
  localparam int unsigned M   = calc_m(N, K);
  localparam int unsigned XAW = calc_xaw(N);
  localparam int unsigned WAW = calc_waw(K);
  localparam int unsigned KW  = cnt_w(K);
  localparam int unsigned MW  = cnt_w(M);

  conv_state_t state_q, state_d;
  logic        mac_en_q;
  logic        ij_clr, ij_inc, ij_last;
  logic        rc_clr, rc_inc, rc_last;
  logic [KW-1:0] i, j;
  logic [MW-1:0] r, c;
  logic [XAW-1:0] xa;
  logic [WAW-1:0] wa;

  conv_idx_counter #(.INNER(K), .OUTER(K)) u_ij (
    .clk(clk), .reset(reset), .clr_i(ij_clr), .inc_i(ij_inc),
    .inner_o(j), .outer_o(i), .last_o(ij_last)
  );

  conv_idx_counter #(.INNER(M), .OUTER(M)) u_rc (
    .clk(clk), .reset(reset), .clr_i(rc_clr), .inc_i(rc_inc),
    .inner_o(c), .outer_o(r), .last_o(rc_last)
  );

  always_comb begin
    state_d = state_q;
    ij_clr  = 1'b0;
    ij_inc  = 1'b0;
    rc_clr  = 1'b0;
    rc_inc  = 1'b0;
    unique case (state_q)
      IDLE:  if (bus.start) begin
               rc_clr  = 1'b1;
               state_d = CLEAR;
             end
      CLEAR: begin
               ij_clr  = 1'b1;
               state_d = ACCUM;
             end
      ACCUM: begin
               ij_inc = 1'b1;
               if (ij_last) state_d = FLUSH;
             end
      FLUSH: state_d = EMIT;
      EMIT:  if (bus.OUT_AXIS_TREADY) begin
               rc_inc  = 1'b1;
               state_d = rc_last ? DONE : CLEAR;
             end
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // mac_en lags ACCUM by one cycle to line up with the registered memory read.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      mac_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      mac_en_q <= (state_q == ACCUM);
    end
  end

  assign xa = (XAW'(r) + XAW'(i)) * XAW'(N) + XAW'(c) + XAW'(j);
  assign wa = WAW'(i) * WAW'(K) + WAW'(j);

  assign bus.busy            = (state_q != IDLE);
  assign bus.done            = (state_q == DONE);
  assign bus.mac_clr         = (state_q == CLEAR);
  assign bus.mac_en          = mac_en_q;
  assign bus.OUT_AXIS_TVALID = (state_q == EMIT);
  assign bus.x_addr          = (state_q == ACCUM) ? xa : '0;
  assign bus.w_addr          = (state_q == ACCUM) ? wa : '0;
endmodule
